// File: rtl/morse_pkg.sv
// Shared types for the Morse letter controller: symbol codes, FSM states and
// the live press-class encoding shown on the LEDs.
package morse_pkg;

   localparam logic [1:0] SYM_SHORT = 2'b10;
   localparam logic [1:0] SYM_LONG  = 2'b11;
   localparam logic [1:0] SYM_SPACE = 2'b00;

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      CLASSIFY,
      OUT
   } state_t;

   typedef enum logic [1:0] {
      CLS_NONE  = 2'b00,
      CLS_SHORT = 2'b01,
      CLS_LONG  = 2'b10,
      CLS_SPACE = 2'b11
   } sym_class_t;

   // Map a valid press class onto the code stored in the letter register.
   function automatic logic [1:0] sym_code(input sym_class_t cls);
      logic [1:0] code;
      code = SYM_SPACE;
      case (cls)
         CLS_SHORT: code = SYM_SHORT;
         CLS_LONG:  code = SYM_LONG;
         default:   code = SYM_SPACE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/press_timer.sv
// Saturating tick counter with synchronous clear; times key presses and,
// when auto-commit is built, the idle gap between them.
module press_timer #(
   parameter int CNT_W = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/morse_letter_ctrl.sv
// Morse letter controller: times key presses, packs symbols into a letter and
// hands it downstream over valid/ready. Optional MORSE_AUTO_COMMIT_EN commits
// a letter after GAP_TICKS idle ticks.
module morse_letter_ctrl #(
   parameter int CNT_W     = 17,
   parameter int SHORT_MAX = 2000,
   parameter int LONG_MIN  = 4000,
   parameter int LONG_MAX  = 7000,
   parameter int MAX_SYM   = 5,
   parameter int GAP_TICKS = 14000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 key_down,
   input  logic                 key_up,
   input  logic                 del_pulse,
   input  logic                 fin_pulse,
   output logic [2*MAX_SYM-1:0] letter_data,
   output logic [2:0]           letter_len,
   output logic                 letter_valid,
   input  logic                 letter_ready,
   output logic [1:0]           sym_class,
   output logic                 err,
   output logic                 full
);

   import morse_pkg::*;

   localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_MAX);
   localparam logic [CNT_W-1:0] LMIN_C  = CNT_W'(LONG_MIN);
   localparam logic [CNT_W-1:0] LMAX_C  = CNT_W'(LONG_MAX);
   localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_TICKS);
   localparam logic [2:0]       MAX_LEN = 3'(MAX_SYM);

   state_t           state;
   logic [CNT_W-1:0] press_count;
   logic             press_clr;
   logic             press_en;
   sym_class_t       live_class;
   logic             do_commit;

   // Ticks in the key_down cycle are dropped: the clear wins that edge.
   assign press_clr = (state == IDLE) && key_down;
   assign press_en  = (state == PRESS) && tick;

   press_timer #(.CNT_W(CNT_W)) u_press_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (press_clr),
      .en    (press_en),
      .count (press_count)
   );

   // One decoder serves both the LEDs and the CLASSIFY decision.
   always_comb begin
      live_class = CLS_NONE;
      if (press_count == '0) begin
         live_class = CLS_NONE;
      end else if (press_count < SHORT_C) begin
         live_class = CLS_SHORT;
      end else if (press_count < LMIN_C) begin
         live_class = CLS_NONE;
      end else if (press_count <= LMAX_C) begin
         live_class = CLS_LONG;
      end else begin
         live_class = CLS_SPACE;
      end
   end

`ifdef MORSE_AUTO_COMMIT_EN
   logic [CNT_W-1:0] gap_count;
   logic             gap_clr;

   assign gap_clr = (state != IDLE) || (letter_len == '0) || key_down || del_pulse;

   press_timer #(.CNT_W(CNT_W)) u_gap_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (gap_clr),
      .en    (tick),
      .count (gap_count)
   );

   assign do_commit = fin_pulse || (gap_count == GAP_C);
`else
   logic unused_gap;
   assign unused_gap = |GAP_C;
   assign do_commit  = fin_pulse;
`endif

   assign sym_class = (state == PRESS) ? live_class : CLS_NONE;
   assign full      = (letter_len == MAX_LEN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         letter_data  <= '0;
         letter_len   <= '0;
         letter_valid <= 1'b0;
         err          <= 1'b0;
      end else begin
         err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (key_down) begin
                  state <= PRESS;
               end else if (del_pulse) begin
                  if (letter_len != '0) begin
                     letter_data <= letter_data >> 2;
                     letter_len  <= letter_len - 3'd1;
                  end
               end else if (do_commit && (letter_len != '0)) begin
                  state        <= OUT;
                  letter_valid <= 1'b1;
               end
            end
            PRESS: begin
               if (del_pulse) begin
                  state <= IDLE;
               end else if (key_up) begin
                  state <= CLASSIFY;
               end
            end
            CLASSIFY: begin
               state <= IDLE;
               if (full || (live_class == CLS_NONE)) begin
                  err <= 1'b1;
               end else begin
                  letter_data <= {letter_data[2*MAX_SYM-3:0], sym_code(live_class)};
                  letter_len  <= letter_len + 3'd1;
               end
            end
            OUT: begin
               // Data and length stay frozen until the translator accepts.
               if (letter_ready) begin
                  state        <= IDLE;
                  letter_valid <= 1'b0;
                  letter_data  <= '0;
                  letter_len   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_letter_ctrl.sv
// Directed bench for morse_letter_ctrl: a letter model predicts each append,
// delete and commit; committed letters are queued and matched on transfer.
module tb_morse_letter_ctrl;

   typedef struct packed {
      logic [9:0] data;
      logic [2:0] len;
   } letter_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b1;
   logic       key_down = 1'b0;
   logic       key_up = 1'b0;
   logic       del_pulse = 1'b0;
   logic       fin_pulse = 1'b0;
   logic       letter_ready = 1'b1;
   logic [9:0] letter_data;
   logic [2:0] letter_len;
   logic       letter_valid;
   logic [1:0] sym_class;
   logic       err;
   logic       full;

   int         checks = 0;
   int         failures = 0;
   int         n_xfer = 0;
   int         n_exp_xfer = 0;
   letter_t    exp_q[$];
   logic [9:0] exp_data = '0;
   logic [2:0] exp_len = '0;

   morse_letter_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .key_down     (key_down),
      .key_up       (key_up),
      .del_pulse    (del_pulse),
      .fin_pulse    (fin_pulse),
      .letter_data  (letter_data),
      .letter_len   (letter_len),
      .letter_valid (letter_valid),
      .letter_ready (letter_ready),
      .sym_class    (sym_class),
      .err          (err),
      .full         (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] cls_of(input int c);
      if (c == 0)    return 2'b00;
      if (c < 2000)  return 2'b01;
      if (c < 4000)  return 2'b00;
      if (c <= 7000) return 2'b10;
      return 2'b11;
   endfunction

   function automatic logic [1:0] code_of(input logic [1:0] cls);
      case (cls)
         2'b01:   return 2'b10;
         2'b10:   return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Transfers are sampled mid-cycle: valid&&ready here means the next edge accepts.
   always @(negedge clk) begin
      if (!rst && (letter_valid === 1'b1) && (letter_ready === 1'b1)) begin
         letter_t e;
         n_xfer++;
         check("xfer_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("xfer_data", letter_data, e.data);
            check("xfer_len", letter_len, e.len);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds the key for n counted ticks (tick is high every cycle), then lets
   // CLASSIFY complete before comparing against the letter model.
   task automatic press(input int n);
      logic [1:0] cls;
      key_down = 1'b1;
      step();
      key_down = 1'b0;
      repeat (n - 1) step();
      check("sym_class_live", sym_class, cls_of(n - 1));
      key_up = 1'b1;
      step();
      key_up = 1'b0;
      step();
      cls = cls_of(n);
      if ((cls == 2'b00) || (exp_len == 3'd5)) begin
         check("err_pulse", err, 1);
      end else begin
         exp_data = {exp_data[7:0], code_of(cls)};
         exp_len  = exp_len + 3'd1;
         check("err_quiet", err, 0);
      end
      check("len_after", letter_len, exp_len);
      check("data_after", letter_data, exp_data);
      check("full_after", full, exp_len == 3'd5);
      check("sym_class_idle", sym_class, 0);
   endtask

   task automatic fin();
      letter_t e;
      e.data = exp_data;
      e.len  = exp_len;
      exp_q.push_back(e);
      fin_pulse = 1'b1;
      step();
      fin_pulse = 1'b0;
      check("valid_rise", letter_valid, 1);
   endtask

   task automatic wait_xfer();
      for (int i = 0; i < 20; i++) begin
         if (letter_valid === 1'b0) break;
         step();
      end
      n_exp_xfer++;
      exp_data = '0;
      exp_len  = '0;
      check("valid_drop", letter_valid, 0);
      check("len_clear", letter_len, 0);
      check("data_clear", letter_data, 0);
   endtask

   initial begin
      // Reset state
      step();
      step();
      check("rst_valid", letter_valid, 0);
      check("rst_len", letter_len, 0);
      check("rst_data", letter_data, 0);
      check("rst_err", err, 0);
      check("rst_class", sym_class, 0);
      check("rst_full", full, 0);
      rst = 1'b0;
      step();

      // Single short symbol, committed with ready already high
      press(1000);
      check("short_code", letter_data, 10'h002);
      fin();
      wait_xfer();

      // Short, long, space
      press(1000);
      press(5000);
      press(9000);
      check("sls_code", letter_data, 10'b00_00_10_11_00);
      check("sls_len", letter_len, 3);
      fin();
      wait_xfer();

      // Dead-zone press is rejected with a one-cycle err
      press(3000);
      step();
      check("err_one_cycle", err, 0);

      // Fill the letter, overflow, then delete one symbol
      for (int i = 0; i < 6; i++) press(500);
      check("full_len", letter_len, 5);
      del_pulse = 1'b1;
      step();
      del_pulse = 1'b0;
      exp_data = exp_data >> 2;
      exp_len  = exp_len - 3'd1;
      check("del_len", letter_len, exp_len);
      check("del_data", letter_data, exp_data);
      check("del_full", full, 0);
      fin();
      wait_xfer();

      // Back-pressure: valid and data hold, inputs ignored in OUT
      press(1000);
      press(4500);
      letter_ready = 1'b0;
      fin();
      for (int i = 0; i < 10; i++) begin
         key_down  = i[0];
         del_pulse = ~i[0];
         step();
         key_down  = 1'b0;
         del_pulse = 1'b0;
         check("hold_valid", letter_valid, 1);
         check("hold_data", letter_data, exp_data);
         check("hold_len", letter_len, 2);
         check("hold_class", sym_class, 0);
      end
      letter_ready = 1'b1;
      wait_xfer();
      press(1000);
      fin();
      wait_xfer();

      // Idle gap after a long press: commits only with auto-commit built
      letter_ready = 1'b0;
      press(5000);
      for (int i = 0; i < 14100; i++) begin
         if (letter_valid === 1'b1) break;
         step();
      end
`ifdef MORSE_AUTO_COMMIT_EN
      check("auto_commit", letter_valid, 1);
`else
      check("no_auto_commit", letter_valid, 0);
`endif
      if (letter_valid !== 1'b1) fin();

      // Reset while OUT drops everything
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      exp_data = '0;
      exp_len  = '0;
      check("rst_out_valid", letter_valid, 0);
      check("rst_out_len", letter_len, 0);
      check("rst_out_data", letter_data, 0);

      // Reset mid-press, then a clean press still times correctly
      letter_ready = 1'b1;
      key_down = 1'b1;
      step();
      key_down = 1'b0;
      repeat (50) step();
      check("mid_press_class", sym_class, cls_of(50));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_press_class", sym_class, 0);
      check("rst_press_len", letter_len, 0);
      step();
      press(1000);
      fin();
      wait_xfer();

      step();
      check("xfer_count", n_xfer, n_exp_xfer);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
